// File: rtl/cfs_apb_arb_pkg.sv
// Shared types and width helpers for the APB master arbiter.
package cfs_apb_arb_pkg;

    // APB transfer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    localparam int MIN_REQ = 2;
    localparam int MAX_REQ = 8;

    // Width of an index able to address n items; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfs_apb_rr_arbiter.sv
// Combinational round-robin grant: first valid requester above last_grant, with wrap.
module cfs_apb_rr_arbiter
    import cfs_apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    // Scan candidates in priority order last_grant+1, last_grant+2, ... wrapping once
    always_comb begin : p_rr
        int unsigned         v_idx;
        logic [IDX_W-1:0]    v_sel;
        logic                v_found;
        o_grant     = '0;
        o_grant_idx = '0;
        v_found     = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            v_idx = (32'(i_last_grant) + k) % NUM_REQ;
            v_sel = IDX_W'(v_idx);
            if (!v_found && i_req_valid[v_sel]) begin
                v_found        = 1'b1;
                o_grant[v_sel] = 1'b1;
                o_grant_idx    = v_sel;
            end
        end
    end

endmodule

// File: rtl/cfs_apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters,
// with SETUP/ACCESS sequencing, response return and an ACCESS-phase timeout.
module cfs_apb_master_arbiter
    import cfs_apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          pwrite,
    output logic                          psel,
    output logic                          penable,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic                          pready,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pslverr,
    output logic                          timeout_pulse
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = idx_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t            r_state;
    logic [IDX_W-1:0]      r_last_grant;
    logic [CNT_W-1:0]      r_tmo_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_timeout_pulse;

    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_handshake;
    logic                  w_tmo_hit;
    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    cfs_apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    // Grants are only offered while idle; any set ready bit implies a handshake
    assign req_ready   = (r_state == ST_IDLE) ? w_grant : '0;
    assign w_handshake = |req_ready;
    assign w_tmo_hit   = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_LAST);

    assign psel          = (r_state != ST_IDLE);
    assign penable       = (r_state == ST_ACCESS);
    assign paddr         = r_paddr;
    assign pwrite        = r_pwrite;
    assign pwdata        = r_pwdata;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;
    assign timeout_pulse = r_timeout_pulse;

    // Transfer FSM: accept, SETUP, ACCESS with wait states / timeout, respond
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state         <= ST_IDLE;
            r_last_grant    <= IDX_W'(NUM_REQ - 1);
            r_tmo_cnt       <= '0;
            r_paddr         <= '0;
            r_pwrite        <= 1'b0;
            r_pwdata        <= '0;
            r_rsp_valid     <= '0;
            r_rsp_rdata     <= '0;
            r_rsp_err       <= 1'b0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_rsp_valid     <= '0;
            r_timeout_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_paddr      <= w_addr_arr[w_grant_idx];
                        r_pwrite     <= req_write[w_grant_idx];
                        r_pwdata     <= w_wdata_arr[w_grant_idx];
                        r_last_grant <= w_grant_idx;
                        r_state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_rsp_err   <= pslverr;
                        r_rsp_valid <= NUM_REQ'(1) << r_last_grant;
                        r_tmo_cnt   <= '0;
                        r_state     <= ST_IDLE;
                    end else if (w_tmo_hit) begin
                        r_rsp_rdata     <= '0;
                        r_rsp_err       <= 1'b1;
                        r_rsp_valid     <= NUM_REQ'(1) << r_last_grant;
                        r_timeout_pulse <= 1'b1;
                        r_tmo_cnt       <= '0;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfs_apb_master_arbiter.sv
// Self-checking bench for cfs_apb_master_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_cfs_apb_master_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic              pclk = 1'b0;
    logic              preset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_write;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DW-1:0]     pwdata;
    logic              pready;
    logic [DW-1:0]     prdata;
    logic              pslverr;
    logic              timeout_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: requester payloads and the round-robin pointer
    logic [AW-1:0] m_addr  [NR];
    logic          m_write [NR];
    logic [DW-1:0] m_wdata [NR];
    int            m_last;

    always #5 pclk = ~pclk;

    cfs_apb_master_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk          (pclk),
        .preset_n      (preset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_write     (req_write),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .paddr         (paddr),
        .pwrite        (pwrite),
        .psel          (psel),
        .penable       (penable),
        .pwdata        (pwdata),
        .pready        (pready),
        .prdata        (prdata),
        .pslverr       (pslverr),
        .timeout_pulse (timeout_pulse)
    );

    // Winner = first valid requester after the last winner, wrapping around
    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic drive_payload();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = m_addr[i];
            req_write[i]          = m_write[i];
            req_wdata[i*DW +: DW] = m_wdata[i];
        end
    endtask

    task automatic do_reset();
        preset_n  = 1'b0;
        req_valid = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        repeat (3) @(posedge pclk);
        #1 preset_n = 1'b1;
        m_last = NR - 1;
    endtask

    // One complete transfer; the ACCESS phase sees `waits` cycles of pready=0
    // before pready=1, unless the timeout model aborts it first.
    task automatic xfer(input logic [NR-1:0] vmask, input int waits,
                        input logic serr, input logic [DW-1:0] rd, output int win);
        logic [NR-1:0] exp_oh;
        logic [AW-1:0] e_addr;
        logic          e_write;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_rdata;
        logic          e_err;
        bit            tmo;
        drive_payload();
        req_valid = vmask;
        win = rr_pick(vmask, m_last);
        exp_oh = (win < 0) ? '0 : (NR'(1) << win);
        #1;
        n_checks++;
        if (req_ready !== exp_oh) $display("FAIL grant: req_ready=%b expected=%b", req_ready, exp_oh);
        else n_pass++;
        if (win < 0) begin
            @(posedge pclk); #1;
            req_valid = '0;
            return;
        end
        m_last  = win;
        e_addr  = m_addr[win];
        e_write = m_write[win];
        e_wdata = m_wdata[win];
        // SETUP cycle: slave inputs carry noise that must be ignored
        @(posedge pclk); #1;
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        @(negedge pclk);
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== e_addr || pwrite !== e_write ||
            (e_write && pwdata !== e_wdata) || req_ready !== '0 || rsp_valid !== '0)
            $display("FAIL setup: psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h ready=%b rsp=%b expected 1 0 %h %b %h 0 0",
                     psel, penable, paddr, pwrite, pwdata, req_ready, rsp_valid, e_addr, e_write, e_wdata);
        else n_pass++;
        tmo = 0;
        for (int k = 0; k <= waits; k++) begin
            @(posedge pclk); #1;
            pready  = (k == waits);
            pslverr = (k == waits) ? serr : 1'($urandom_range(0, 1));
            prdata  = (k == waits) ? rd : $urandom;
            @(negedge pclk);
            n_checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || paddr !== e_addr || pwrite !== e_write ||
                req_ready !== '0 || rsp_valid !== '0 || timeout_pulse !== 1'b0)
                $display("FAIL access[%0d]: psel=%b penable=%b paddr=%h ready=%b rsp=%b tp=%b expected 1 1 %h 0 0 0",
                         k, psel, penable, paddr, req_ready, rsp_valid, timeout_pulse, e_addr);
            else n_pass++;
            if (k < waits && TMO != 0 && k == TMO - 1) begin
                tmo = 1;
                break;
            end
        end
        @(posedge pclk); #1;
        pready    = 1'b0;
        req_valid = '0;
        e_err   = tmo ? 1'b1 : serr;
        e_rdata = (tmo || e_write) ? '0 : rd;
        @(negedge pclk);
        n_checks++;
        if (rsp_valid !== exp_oh || rsp_err !== e_err || rsp_rdata !== e_rdata ||
            timeout_pulse !== tmo || psel !== 1'b0 || penable !== 1'b0)
            $display("FAIL response: rsp_valid=%b err=%b rdata=%h tp=%b psel=%b penable=%b expected %b %b %h %b 0 0",
                     rsp_valid, rsp_err, rsp_rdata, timeout_pulse, psel, penable, exp_oh, e_err, e_rdata, tmo);
        else n_pass++;
    endtask

    task automatic test_reset();
        int w;
        do_reset();
        preset_n = 1'b0;
        req_valid = '1;
        @(posedge pclk);
        @(negedge pclk);
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0 ||
            rsp_valid !== '0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || timeout_pulse !== 1'b0)
            $display("FAIL reset_values: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h rsp=%b rdata=%h err=%b tp=%b expected all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, timeout_pulse);
        else n_pass++;
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL reset_priority: req_ready=%b expected=01", req_ready);
        else n_pass++;
        req_valid = '0;
        #1;
        n_checks++;
        if (req_ready !== '0) $display("FAIL no_request: req_ready=%b expected=00", req_ready);
        else n_pass++;
        #1 preset_n = 1'b1;
        @(posedge pclk); #1;
        w = 0;
    endtask

    task automatic test_single_write();
        int w;
        do_reset();
        m_addr[0] = 16'h0010; m_write[0] = 1'b1; m_wdata[0] = 32'hDEADBEEF;
        xfer(2'b01, 0, 1'b0, 32'h0, w);
        n_checks++;
        if (w !== 0) $display("FAIL single_write_winner: got=%0d expected=0", w);
        else n_pass++;
    endtask

    task automatic test_read_waits();
        int w;
        m_addr[1] = 16'h0024; m_write[1] = 1'b0; m_wdata[1] = 32'h0;
        xfer(2'b10, 3, 1'b0, 32'h12345678, w);
        n_checks++;
        if (w !== 1) $display("FAIL read_winner: got=%0d expected=1", w);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int w;
        int order [4] = '{0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < NR; i++) begin
            m_addr[i] = AW'(16'h0100 + 16'(i)); m_write[i] = 1'b1; m_wdata[i] = DW'(i);
        end
        for (int n = 0; n < 4; n++) begin
            xfer(2'b11, 0, 1'b0, 32'h0, w);
            n_checks++;
            if (w !== order[n]) $display("FAIL fairness[%0d]: winner=%0d expected=%0d", n, w, order[n]);
            else n_pass++;
        end
    endtask

    task automatic test_slave_error();
        int w;
        m_addr[0] = 16'h0030; m_write[0] = 1'b1; m_wdata[0] = 32'hCAFEF00D;
        xfer(2'b01, 0, 1'b1, 32'h0, w);
        m_addr[1] = 16'h0034; m_write[1] = 1'b0;
        xfer(2'b10, 1, 1'b0, 32'hA5A5_0001, w);
    endtask

    task automatic test_timeout();
        int w;
        m_addr[0] = 16'h0050; m_write[0] = 1'b0;
        xfer(2'b01, TMO + 4, 1'b0, 32'hFFFF_FFFF, w);
        @(posedge pclk); #1;
        @(negedge pclk);
        n_checks++;
        if (timeout_pulse !== 1'b0 || psel !== 1'b0 || rsp_valid !== '0)
            $display("FAIL timeout_after: tp=%b psel=%b rsp=%b expected 0 0 00", timeout_pulse, psel, rsp_valid);
        else n_pass++;
        // pready arriving in the last allowed cycle still completes normally
        xfer(2'b01, TMO - 1, 1'b0, 32'h0BAD_F00D, w);
    endtask

    task automatic test_reset_mid();
        int w;
        m_addr[1] = 16'h0040; m_write[1] = 1'b0;
        drive_payload();
        req_valid = 2'b10;
        pready = 1'b0;
        @(posedge pclk); #1;
        req_valid = '0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        @(negedge pclk);
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b1) $display("FAIL mid_access: psel=%b penable=%b expected 1 1", psel, penable);
        else n_pass++;
        preset_n = 1'b0;
        @(posedge pclk); #1;
        @(negedge pclk);
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== '0)
            $display("FAIL mid_reset: psel=%b penable=%b rsp=%b expected 0 0 00", psel, penable, rsp_valid);
        else n_pass++;
        @(posedge pclk); #1;
        preset_n = 1'b1;
        m_last = NR - 1;
        m_write[0] = 1'b1; m_addr[0] = 16'h0060; m_wdata[0] = 32'h0000_0060;
        xfer(2'b11, 0, 1'b0, 32'h0, w);
        n_checks++;
        if (w !== 0) $display("FAIL post_reset_winner: got=%0d expected=0", w);
        else n_pass++;
    endtask

    task automatic test_random();
        int w;
        int waits;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NR; i++) begin
                m_addr[i]  = AW'($urandom);
                m_write[i] = 1'($urandom_range(0, 1));
                m_wdata[i] = $urandom;
            end
            waits = ($urandom_range(0, 9) == 0) ? TMO + 2 : int'($urandom_range(0, 4));
            xfer(NR'($urandom_range(0, 3)), waits, 1'($urandom_range(0, 3) == 0), $urandom, w);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge pclk); #1;
            end
        end
    endtask

    initial begin
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        preset_n  = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        m_last    = NR - 1;
        for (int i = 0; i < NR; i++) begin
            m_addr[i] = '0; m_write[i] = 1'b0; m_wdata[i] = '0;
        end
        test_reset();
        test_single_write();
        test_read_waits();
        test_fairness();
        test_slave_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cfs_apb_master_arbiter.md
Name: cfs_apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ on-chip requesters using round-robin arbitration.
- Sequences each transfer through the APB SETUP and ACCESS phases.
- Returns read data and error status to the winning requester.
- Guards against a hung slave with an ACCESS-phase timeout.
- Sits between internal register-access masters and the APB bus driven into the cfs_apb interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 16, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, ACCESS cycles with pready=0 before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_ready  out  NUM_REQ  one-hot accept; transfer taken when valid&ready.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid.
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_WIDTH  slave read data.
- pslverr  in  1  slave error.
- timeout_pulse  out  1  one-cycle pulse on each timeout abort.

Behaviour:
- Reset (preset_n=0 at clock edge):
  - Next cycle: state=IDLE; psel, penable, pwrite, paddr, pwdata = 0; rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout_pulse=0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational: one-hot grant = first asserted req_valid searching from last_grant+1 upward, with wrap.
  - req_ready is all-zero outside IDLE and when no request is valid.
  - On handshake, latch addr/write/wdata into paddr/pwrite/pwdata, set last_grant=winner, go to SETUP.
- SETUP: psel=1, penable=0, unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1.
  - If pready=1: register rsp_rdata = pwrite ? 0 : prdata and rsp_err = pslverr; pulse rsp_valid[winner] next cycle; go to IDLE.
  - Else: increment the timeout counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with pready=0: abort; rsp_err=1, rsp_rdata=0, timeout_pulse=1, go to IDLE.
  - The counter clears on leaving ACCESS.
- Latency:
  - Handshake at cycle T → SETUP at T+1 → ACCESS at T+2.
  - With zero wait states, rsp_valid at T+3, and the next handshake is possible in that same cycle (state IDLE).
  - Each wait state adds one cycle.
- Timing rules:
  - psel/penable are decoded from the registered state.
  - paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS.
  - psel drops to 0 in the cycle after completion.
- pready/pslverr/prdata are ignored outside ACCESS.
- Simultaneous requests: exactly one grant. With continuous requests, requesters alternate in round-robin order; no requester waits more than NUM_REQ-1 transfers.
- Requesters must hold valid and payload until ready. Dropping valid before ready is allowed; no grant results.
- Reset mid-transfer: abandons the transfer with no rsp_valid; psel=0 the next cycle.
- A timeout abort deliberately deasserts psel without pready. The slave must tolerate this; flag it in integration notes.

Decomposition:
- Package cfs_apb_arb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - localparam helpers for the grant-index width ($clog2(NUM_REQ)).
- Sub-module cfs_apb_rr_arbiter: pure combinational round-robin grant from req_valid and last_grant, returning a one-hot grant and its index.

Test Plan:
- Single write:
  - Stimulus: req0 write addr 0x0010 data 0xDEADBEEF, pready=1 in the first ACCESS cycle.
  - Response: psel=1/penable=0 at T+1, penable=1 at T+2, rsp_valid=01 at T+3, rsp_err=0.
- Read with 3 wait states:
  - Stimulus: req1 read addr 0x0024; pready=0 for 3 ACCESS cycles, then 1 with prdata=0x12345678.
  - Response: rsp_valid=10 at T+6, rsp_rdata=0x12345678; paddr stable throughout.
- Arbitration fairness:
  - Stimulus: req0 and req1 both valid continuously for 4 transfers after reset.
  - Response: grant order 0,1,0,1; req_ready never has more than one bit set.
- Slave error:
  - Stimulus: req0 write with pslverr=1 and pready=1.
  - Response: rsp_err=1, rsp_valid=01; the next transfer completes normally.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, pready held 0.
  - Response: after the 16th ACCESS cycle, rsp_err=1, rsp_rdata=0, timeout_pulse high one cycle, psel=0 the following cycle.
- Reset mid-ACCESS:
  - Stimulus: assert preset_n=0 during a wait-stated read.
  - Response: psel=penable=0 and rsp_valid=0 after the edge; after release, req0 is granted first.
